// File: rtl/uart_tx_fifo.sv
// Byte FIFO between a CPU store port and a UART transmitter, with a pipeline stall while full.
// Optional sticky overflow flag is enabled by defining UART_TX_FIFO_OVERFLOW_FLAG_EN.
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             stall_req,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
    ,
    output logic             overflow
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wp_r;
    logic [PTR_W-1:0] rp_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

    // Status and handshakes; full uses the pre-edge count so a pop never frees room for a same-cycle push.
    always_comb begin
        full_s    = (count_r == CNT_W'(DEPTH));
        empty_s   = (count_r == {CNT_W{1'b0}});
        push_s    = wr_en && !full_s;
        pop_s     = !empty_s && tx_ready;
        stall_req = wr_en && full_s;
        tx_valid  = !empty_s;
        tx_data   = mem_r[rp_r];
        full      = full_s;
        empty     = empty_s;
        count     = count_r;
    end

    // Pointer and occupancy state; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_r    <= {PTR_W{1'b0}};
            rp_r    <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wp_r <= wp_r + PTR_W'(1);
            end else begin
                wp_r <= wp_r;
            end
            if (pop_s) begin
                rp_r <= rp_r + PTR_W'(1);
            end else begin
                rp_r <= rp_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Byte storage; contents are meaningless until written, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wp_r] <= wr_data;
        end
    end

`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
    logic overflow_r;

    // Sticky record of any store attempted while full; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else if (wr_en && full_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign overflow = overflow_r;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a queue model of the FIFO predicts occupancy, stalls and byte order.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             stall_req;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
    logic             overflow;
`endif

    uart_tx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .stall_req(stall_req), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .count(count), .full(full), .empty(empty)
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
        , .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         passed = 0;
    logic [7:0] exp_q[$];
    int         model_cnt = 0;
    int         exp_pre = 0;
    bit         exp_stall = 1'b0;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Apply one cycle of inputs and record what the ideal FIFO does with them.
    task automatic drive(input bit w, input logic [7:0] d, input bit r);
        bit push;
        bit pop;
        wr_en    = w;
        wr_data  = d;
        tx_ready = r;
        exp_pre   = model_cnt;
        exp_stall = w && (model_cnt == DEPTH);
        push = w && (model_cnt < DEPTH);
        pop  = r && (model_cnt > 0);
        if (push) exp_q.push_back(d);
        model_cnt = model_cnt + int'(push) - int'(pop);
    endtask

    task automatic cycle(input bit w, input logic [7:0] d, input bit r);
        @(negedge clk);
        drive(w, d, r);
    endtask

    // Monitor: compares status every cycle and pops the scoreboard on each accepted handshake.
    always begin
        @(negedge clk);
        #4;
        if (mon_en) begin
            chk("count", 32'(count), 32'(exp_pre));
            chk("empty", 32'(empty), 32'(exp_pre == 0));
            chk("full", 32'(full), 32'(exp_pre == DEPTH));
            chk("tx_valid", 32'(tx_valid), 32'(exp_pre != 0));
            chk("stall_req", 32'(stall_req), 32'(exp_stall));
            if (exp_pre != 0 && exp_q.size() > 0) chk("tx_data_head", 32'(tx_data), 32'(exp_q[0]));
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL pop_data: got 0x%0h popped, expected no byte pending at %0t", tx_data, $time);
                end else begin
                    chk("pop_data", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_ready = 1'b0;
        #3;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
        chk("rst_overflow", 32'(overflow), 32'd0);
`endif

        // Release reset and push on the very first rising edge afterwards.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 8'h41, 1'b0);
        mon_en = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Fill to full, then a stalled ninth store.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'h08, 1'b0);
        cycle(1'b1, 8'h08, 1'b1);
        cycle(1'b1, 8'h08, 1'b0);
`ifdef UART_TX_FIFO_OVERFLOW_FLAG_EN
        #2;
        chk("overflow_sticky", 32'(overflow), 32'd1);
`endif
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Simultaneous push/pop at count 3, wrapping pointers.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
        cycle(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'($urandom), 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Build count to 5 then reset between edges mid-transfer.
        cycle(1'b1, 8'h60, 1'b0);
        cycle(1'b1, 8'h61, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        wr_en = 1'b1;
        rst = 1'b0;
        #1;
        chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_full", 32'(full), 32'd0);
        chk("mid_rst_stall", 32'(stall_req), 32'd0);
        exp_q.delete();
        model_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        mon_en = 1'b1;
        cycle(1'b1, 8'h99, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 45));

        // Bounded drain.
        for (int i = 0; i < 4 * DEPTH && model_cnt > 0; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() == 0 && model_cnt == 0) passed++;
        else $display("FAIL drain: got %0d bytes left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
